// File: rtl/izh_pkg.sv
// Shared types and constants for the time-multiplexed Izhikevich neuron scheduler.
package izh_pkg;

  typedef logic signed [17:0] fix_t;

  localparam fix_t P     = 18'sh0_4CCC;
  localparam fix_t C14   = 18'sh1_6666;
  localparam fix_t V_RST = 18'sh3_4CCD;
  localparam fix_t U_RST = 18'sh3_CCCD;
  localparam logic [3:0] A_RST = 4'd2;
  localparam logic [3:0] B_RST = 4'd2;
  localparam fix_t C_RST = 18'sh3_599A;
  localparam fix_t D_RST = 18'sh0_147B;
  localparam fix_t I_RST = 18'sh0_0000;

  typedef enum logic [2:0] {
    SelV  = 3'd0,
    SelU  = 3'd1,
    SelAb = 3'd2,
    SelC  = 3'd3,
    SelD  = 3'd4,
    SelI  = 3'd5
  } cfg_sel_e;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWrite,
    StStall,
    StDone
  } state_e;

endpackage

// File: rtl/izh_update_core.sv
// Combinational single-neuron Izhikevich update in signed 2.16 fixed point.
module izh_update_core
  import izh_pkg::*;
(
  input  fix_t       v_i,
  input  fix_t       u_i,
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  fix_t       c_i,
  input  fix_t       d_i,
  input  fix_t       i_i,
  output fix_t       v_next_o,
  output fix_t       u_next_o,
  output logic       spike_o
);

  logic signed [35:0] v_prod;
  fix_t v_sq, dv_acc, du_acc;
  logic unused_prod;

  assign v_prod = v_i * v_i;
  // Product keeps its sign bit and drops the two redundant integer bits.
  assign v_sq = {v_prod[35], v_prod[32:16]};
  assign unused_prod = ^{v_prod[34:33], v_prod[15:0]};

  always_comb begin
    dv_acc   = v_sq + v_i + (v_i >>> 2) + (C14 >>> 2) - (u_i >>> 2) + (i_i >>> 2);
    du_acc   = (v_i >>> b_i) - u_i;
    spike_o  = v_i > P;
    v_next_o = v_i + (dv_acc >>> 2);
    u_next_o = u_i + ((du_acc >>> a_i) >>> 4);
    if (spike_o) begin
      v_next_o = c_i;
      u_next_o = u_i + d_i;
    end
  end

endmodule

// File: rtl/izh_neuron_scheduler.sv
// Shares one Izhikevich update core across NUM_NEURONS virtual neurons and queues spikes.
// Optional voltage monitor enabled by defining IZH_SCHED_MON_EN.
module izh_neuron_scheduler
  import izh_pkg::*;
#(
  parameter int unsigned NUM_NEURONS = 8,
  parameter int unsigned IDX_W       = $clog2(NUM_NEURONS),
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  output logic             busy_o,
  output logic             done_o,
  input  logic             cfg_we_i,
  input  logic [IDX_W-1:0] cfg_idx_i,
  input  logic [2:0]       cfg_sel_i,
  input  logic [17:0]      cfg_data_i,
  output logic             cfg_err_o,
  output logic             spike_valid_o,
  input  logic             spike_ready_i,
  output logic [IDX_W-1:0] spike_idx_o,
  input  logic [IDX_W-1:0] mon_idx_i,
  output logic [7:0]       v_mon_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] k_q, k_d;
  fix_t             v_q [NUM_NEURONS];
  fix_t             u_q [NUM_NEURONS];
  fix_t             c_q [NUM_NEURONS];
  fix_t             d_q [NUM_NEURONS];
  fix_t             i_q [NUM_NEURONS];
  logic [3:0]       a_q [NUM_NEURONS];
  logic [3:0]       b_q [NUM_NEURONS];
  fix_t             pv_q, pu_q, pc_q, pd_q, pi_q;
  logic [3:0]       pa_q, pb_q;
  fix_t             v_nxt, u_nxt;
  logic             spike, commit, push, pop, fifo_full, cfg_wr, cfg_err_q;
  logic [IDX_W-1:0] fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]  wr_q, rd_q;
  logic [PtrW:0]    cnt_q;

  izh_update_core u_core (
    .v_i      (pv_q),
    .u_i      (pu_q),
    .a_i      (pa_q),
    .b_i      (pb_q),
    .c_i      (pc_q),
    .d_i      (pd_q),
    .i_i      (pi_q),
    .v_next_o (v_nxt),
    .u_next_o (u_nxt),
    .spike_o  (spike)
  );

  // Fullness uses the registered count only, so a same-cycle pop never frees a slot.
  assign fifo_full = cnt_q == (PtrW + 1)'(FIFO_DEPTH);
  assign pop       = (cnt_q != '0) && spike_ready_i;
  assign push      = commit && spike;
  assign cfg_wr    = cfg_we_i && (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          state_d = StRead;
          k_d     = '0;
        end
      end
      StRead: state_d = StWrite;
      StWrite, StStall: begin
        if (spike && fifo_full) begin
          state_d = StStall;
        end else begin
          commit = 1'b1;
          if (k_q == IDX_W'(NUM_NEURONS - 1)) begin
            state_d = StDone;
          end else begin
            state_d = StRead;
            k_d     = k_q + 1'b1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      k_q       <= '0;
      cfg_err_q <= 1'b0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      pv_q      <= '0;
      pu_q      <= '0;
      pa_q      <= '0;
      pb_q      <= '0;
      pc_q      <= '0;
      pd_q      <= '0;
      pi_q      <= '0;
      for (int unsigned n = 0; n < NUM_NEURONS; n++) begin
        v_q[n] <= V_RST;
        u_q[n] <= U_RST;
        a_q[n] <= A_RST;
        b_q[n] <= B_RST;
        c_q[n] <= C_RST;
        d_q[n] <= D_RST;
        i_q[n] <= I_RST;
      end
      for (int unsigned n = 0; n < FIFO_DEPTH; n++) begin
        fifo_q[n] <= '0;
      end
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      cfg_err_q <= cfg_we_i && (state_q != StIdle);
      if (state_q == StRead) begin
        pv_q <= v_q[k_q];
        pu_q <= u_q[k_q];
        pa_q <= a_q[k_q];
        pb_q <= b_q[k_q];
        pc_q <= c_q[k_q];
        pd_q <= d_q[k_q];
        pi_q <= i_q[k_q];
      end
      if (commit) begin
        v_q[k_q] <= v_nxt;
        u_q[k_q] <= u_nxt;
      end
      if (cfg_wr) begin
        case (cfg_sel_i)
          SelV:  v_q[cfg_idx_i] <= cfg_data_i;
          SelU:  u_q[cfg_idx_i] <= cfg_data_i;
          SelAb: begin
            a_q[cfg_idx_i] <= cfg_data_i[3:0];
            b_q[cfg_idx_i] <= cfg_data_i[7:4];
          end
          SelC:  c_q[cfg_idx_i] <= cfg_data_i;
          SelD:  d_q[cfg_idx_i] <= cfg_data_i;
          SelI:  i_q[cfg_idx_i] <= cfg_data_i;
          default: ;
        endcase
      end
      if (push) begin
        fifo_q[wr_q] <= k_q;
        wr_q         <= wr_q + 1'b1;
      end
      if (pop) begin
        rd_q <= rd_q + 1'b1;
      end
      cnt_q <= cnt_q + {{PtrW{1'b0}}, push} - {{PtrW{1'b0}}, pop};
    end
  end

  assign busy_o        = state_q != StIdle;
  assign done_o        = state_q == StDone;
  assign cfg_err_o     = cfg_err_q;
  assign spike_valid_o = cnt_q != '0;
  assign spike_idx_o   = fifo_q[rd_q];

`ifdef IZH_SCHED_MON_EN
  logic [7:0] mon_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mon_q <= V_RST[17:10];
    end else begin
      mon_q <= v_q[mon_idx_i][17:10];
    end
  end

  assign v_mon_o = mon_q;
`else
  logic unused_mon;

  assign unused_mon = ^mon_idx_i;
  assign v_mon_o    = '0;
`endif

endmodule

// File: tb/tb_izh_neuron_scheduler.sv
// Self-checking bench: cycle-level behavioural model of the scheduler plus literal spot checks.
module tb_izh_neuron_scheduler;

  localparam int N     = 8;
  localparam int DEPTH = 4;
  localparam int P_I   = 19660;  // 0.30
  localparam int C14_I = 91750;  // 1.4

  logic        clk = 1'b0;
  logic        rst, start, cfg_we, spike_ready;
  logic [2:0]  cfg_idx, cfg_sel, mon_idx;
  logic [17:0] cfg_data;
  logic        busy, done, cfg_err, spike_valid;
  logic [2:0]  spike_idx;
  logic [7:0]  v_mon;

  always #5 clk = ~clk;

  izh_neuron_scheduler #(
    .NUM_NEURONS (N),
    .IDX_W       (3),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start),
    .busy_o        (busy),
    .done_o        (done),
    .cfg_we_i      (cfg_we),
    .cfg_idx_i     (cfg_idx),
    .cfg_sel_i     (cfg_sel),
    .cfg_data_i    (cfg_data),
    .cfg_err_o     (cfg_err),
    .spike_valid_o (spike_valid),
    .spike_ready_i (spike_ready),
    .spike_idx_o   (spike_idx),
    .mon_idx_i     (mon_idx),
    .v_mon_o       (v_mon)
  );

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;
  bit rand_ready = 1'b0;
  int done_seen = 0;
  int dut_popped[$];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model ----------------
  typedef enum int {MIdle, MRead, MWrite, MDone} mmode_e;
  int     mv[N], mu[N], ma[N], mb[N], mc[N], md[N], mi[N];
  mmode_e mmode;
  int     mk;
  int     fq[$];
  bit     m_err;
  int     m_mon;

  function automatic int sx18(input longint x);
    longint r;
    r = x % 262144;
    if (r < 0) r += 262144;
    if (r >= 131072) r -= 262144;
    return int'(r);
  endfunction

  function automatic int fmul(input int x, input int y);
    longint m, lo;
    m  = longint'(x) * longint'(y);
    lo = (m / 65536) - ((m < 0 && (m % 65536) != 0) ? 1 : 0);  // floor(m / 2^16)
    lo = lo % 131072;
    if (lo < 0) lo += 131072;
    return int'((m < 0) ? lo - 131072 : lo);
  endfunction

  function automatic void upd(input int v, input int u, input int a, input int b, input int c,
                              input int d, input int i, output int vn, output int un,
                              output bit sp);
    int s, du;
    sp = v > P_I;
    if (sp) begin
      vn = c;
      un = sx18(u + d);
    end else begin
      s  = sx18(fmul(v, v) + v + (v >>> 2) + (C14_I >>> 2) - (u >>> 2) + (i >>> 2));
      vn = sx18(v + (s >>> 2));
      du = sx18((v >>> b) - u);
      un = sx18(u + ((du >>> a) >>> 4));
    end
  endfunction

  function automatic void mreset();
    for (int n = 0; n < N; n++) begin
      mv[n] = sx18(64'h34CCD);
      mu[n] = sx18(64'h3CCCD);
      ma[n] = 2;
      mb[n] = 2;
      mc[n] = sx18(64'h3599A);
      md[n] = sx18(64'h0147B);
      mi[n] = 0;
    end
    mmode = MIdle;
    mk    = 0;
    fq.delete();
    m_err = 1'b0;
    m_mon = 'hD3;
  endfunction

  always @(posedge clk) begin : model
    int vn, un, push_k, mon_new, dval;
    bit sp, full, pop_now;
    if (rst) begin
      mreset();
    end else begin
      push_k  = -1;
      full    = fq.size() >= DEPTH;
      pop_now = (fq.size() > 0) && spike_ready;
      mon_new = (mv[mon_idx] >>> 10) & 255;
      m_err   = cfg_we && (mmode != MIdle);
      case (mmode)
        MIdle: begin
          if (cfg_we) begin
            dval = sx18(longint'(cfg_data));
            case (int'(cfg_sel))
              0: mv[cfg_idx] = dval;
              1: mu[cfg_idx] = dval;
              2: begin
                ma[cfg_idx] = int'(cfg_data[3:0]);
                mb[cfg_idx] = int'(cfg_data[7:4]);
              end
              3: mc[cfg_idx] = dval;
              4: md[cfg_idx] = dval;
              5: mi[cfg_idx] = dval;
              default: ;
            endcase
          end
          if (start) begin
            mmode = MRead;
            mk    = 0;
          end
        end
        MRead: mmode = MWrite;
        MWrite: begin
          upd(mv[mk], mu[mk], ma[mk], mb[mk], mc[mk], md[mk], mi[mk], vn, un, sp);
          // A spiking neuron with a full queue keeps retrying its write.
          if (!(sp && full)) begin
            mv[mk] = vn;
            mu[mk] = un;
            if (sp) push_k = mk;
            if (mk == N - 1) mmode = MDone;
            else begin
              mk++;
              mmode = MRead;
            end
          end
        end
        MDone: mmode = MIdle;
        default: mmode = MIdle;
      endcase
      if (pop_now) void'(fq.pop_front());
      if (push_k >= 0) fq.push_back(push_k);
      m_mon = mon_new;
    end
  end

  always @(negedge clk) begin : compare
    int exp_mon;
`ifdef IZH_SCHED_MON_EN
    exp_mon = m_mon;
`else
    exp_mon = 0;
`endif
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(mmode != MIdle));
      chk("done", 32'(done), 32'(mmode == MDone));
      chk("cfg_err", 32'(cfg_err), 32'(m_err));
      chk("spike_valid", 32'(spike_valid), 32'(fq.size() != 0));
      if (fq.size() != 0) chk("spike_idx", 32'(spike_idx), fq[0]);
      chk("v_mon", 32'(v_mon), exp_mon);
      if (spike_valid && spike_ready) dut_popped.push_back(int'(spike_idx));
      if (done) done_seen++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) spike_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    start  = 1'b0;
    cfg_we = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic cfg(input int idx, input int sel, input int data);
    cfg_we   = 1'b1;
    cfg_idx  = 3'(idx);
    cfg_sel  = 3'(sel);
    cfg_data = 18'(data);
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic run_sweep(input bit noise, output int ncyc);
    int n;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (!done && n < 400) begin
      if (noise) begin
        cfg_we   = ($urandom_range(0, 5) == 0);
        cfg_idx  = 3'($urandom);
        cfg_sel  = 3'($urandom);
        cfg_data = 18'($urandom);
        start    = ($urandom_range(0, 5) == 0);
      end
      tick();
      n++;
      cfg_we = 1'b0;
      start  = 1'b0;
    end
    if (n >= 400) begin
      checks++;
      failures++;
      $display("FAIL sweep_timeout: done not seen within %0d cycles", n);
    end
    ncyc = n;
    tick();
  endtask

  task automatic drain();
    int n = 0;
    spike_ready = 1'b1;
    while (spike_valid && n < 50) begin
      tick();
      n++;
    end
    tick();
  endtask

  initial begin : stim
    int ncyc, seen_before;
    rst = 1'b1; start = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_sel = '0; cfg_data = '0;
    mon_idx = '0; spike_ready = 1'b1;
    do_reset();
    chk_en = 1'b1;
`ifdef IZH_SCHED_MON_EN
    chk("reset_vmon", 32'(v_mon), 32'h0D3);
`else
    chk("reset_vmon", 32'(v_mon), 32'h0);
`endif
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_spike_idx", 32'(spike_idx), 32'h0);

    // Default sweep timing.
    run_sweep(1'b0, ncyc);
    chk("done_cycle", ncyc, 17);

    // Single spike from neuron 3.
    do_reset();
    dut_popped.delete();
    mon_idx = 3'd3;
    cfg(3, 0, 'h05000);
    run_sweep(1'b0, ncyc);
    drain();
    chk("single_spike_cnt", dut_popped.size(), 1);
    if (dut_popped.size() > 0) chk("single_spike_idx", dut_popped[0], 3);
    chk("model_v3", mv[3], sx18(64'h3599A));
    chk("model_u3", mu[3], sx18(64'h3E148));
`ifdef IZH_SCHED_MON_EN
    chk("vmon_v3", 32'(v_mon), 32'h0D6);
`endif

    // Backpressure: every neuron spikes with the consumer stalled.
    do_reset();
    dut_popped.delete();
    for (int n = 0; n < N; n++) cfg(n, 0, 'h05000);
    spike_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (29) tick();
    chk("stall_busy", 32'(busy), 32'h1);
    chk("stall_valid", 32'(spike_valid), 32'h1);
    spike_ready = 1'b1;
    ncyc = 0;
    while (busy && ncyc < 100) begin
      tick();
      ncyc++;
    end
    drain();
    chk("stall_order_len", dut_popped.size(), 8);
    for (int i = 0; i < dut_popped.size() && i < 8; i++) chk("stall_order", dut_popped[i], i);

    // Config write while busy is rejected, same write in idle lands.
    do_reset();
    dut_popped.delete();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    cfg(5, 0, 'h05000);
    chk("cfg_err_pulse", 32'(cfg_err), 32'h1);
    tick();
    chk("cfg_err_clear", 32'(cfg_err), 32'h0);
    while (busy) tick();
    tick();
    cfg(5, 0, 'h05000);
    chk("cfg_err_idle", 32'(cfg_err), 32'h0);
    run_sweep(1'b0, ncyc);
    drain();
    chk("late_cfg_spike_cnt", dut_popped.size(), 1);
    if (dut_popped.size() > 0) chk("late_cfg_spike_idx", dut_popped[0], 5);

    // Reset in the middle of a sweep with spikes queued.
    do_reset();
    for (int n = 0; n < N; n++) cfg(n, 0, 'h05000);
    spike_ready = 1'b0;
    seen_before = done_seen;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    do_reset();
    repeat (3) tick();
    chk("rst_no_done", done_seen, seen_before);
    chk("rst_fifo_empty", 32'(spike_valid), 32'h0);
    spike_ready = 1'b1;
    dut_popped.delete();
    run_sweep(1'b0, ncyc);
    chk("post_rst_done_cycle", ncyc, 17);
    chk("post_rst_no_spike", dut_popped.size(), 0);

    // Randomized sweeps with random configuration, backpressure and interference.
    rand_ready = 1'b1;
    for (int r = 0; r < 25; r++) begin
      mon_idx = 3'($urandom);
      repeat ($urandom_range(0, 5)) cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                                        int'($urandom));
      run_sweep(1'b1, ncyc);
      repeat ($urandom_range(0, 4)) tick();
    end
    rand_ready = 1'b0;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
